// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, Booth digit type and tree-sizing helpers for mul_booth_pipe.
// Latency: n/a (package). Backpressure: n/a.
// Helpers are constant functions so the compressor tree shape follows WIDTH.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_MULH  = 2'b01;
  localparam logic [1:0] MUL_OP_MULHU = 2'b10;

  typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} booth_digit_e;

  // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_e booth_dec(input logic [2:0] bits);
    booth_digit_e d;
    case (bits)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

  // Operands are extended to WIDTH+2 bits, giving WIDTH/2+1 Booth digits.
  function automatic int pp_count(input int width);
    return width / 2 + 1;
  endfunction

  // Rows left after one tree level: each group of 4 -> 2, a leftover 3 -> 2 (full adders),
  // leftover 1 or 2 rows pass straight through.
  function automatic int rows_next(input int n);
    return 2 * (n / 4) + (((n % 4) == 3) ? 2 : (n % 4));
  endfunction

  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = rows_next(r);
    return r;
  endfunction

  function automatic int tree_levels(input int n);
    int r;
    int c;
    r = n;
    c = 0;
    while (r > 2) begin
      r = rows_next(r);
      c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/compressor_4to2.sv
// compressor_4to2: one-column 4:2 compressor (two chained full adders).
// Latency: combinational. Backpressure: n/a.
// Ports: x1..x4,cin (weight j) -> sum (weight j), carry and cout (weight j+1); cout feeds cin of column j+1.
module compressor_4to2 (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;

  // cout depends only on x1..x3, so the column chain never ripples past one column.
  assign s1    = x1 ^ x2 ^ x3;
  assign cout  = (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign sum   = s1 ^ x4 ^ cin;
  assign carry = (s1 & x4) | (s1 & cin) | (x4 & cin);
endmodule

// File: rtl/mul_booth_pp.sv
// mul_booth_pp: one radix-4 Booth digit times the extended multiplicand -> one 2*WIDTH partial product row.
// Latency: combinational. Backpressure: n/a.
// Ports: a (WIDTH+2 extended multiplicand), sel (3 multiplier bits), row (unshifted, sign-extended,
//        one's complement when negative), neg (the +1 fix bit completing the two's complement).
module mul_booth_pp
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0]   a,
  input  logic [2:0]         sel,
  output logic [2*WIDTH-1:0] row,
  output logic               neg
);
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;

  booth_digit_e   dig;
  logic [PW-1:0]  a_ext;
  logic [PW-1:0]  mag;

  assign dig   = booth_dec(sel);
  assign a_ext = {{(PW - EW){a[EW-1]}}, a};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (dig)
      BD_P1: mag = a_ext;
      BD_P2: mag = a_ext << 1;
      BD_M1: begin mag = a_ext;      neg = 1'b1; end
      BD_M2: begin mag = a_ext << 1; neg = 1'b1; end
      default: mag = '0;
    endcase
  end

  assign row = neg ? ~mag : mag;
endmodule

// File: rtl/mul_booth_pipe.sv
// mul_booth_pipe: pipelined WIDTH x WIDTH Booth radix-4 multiplier, MUL / MULH / MULHU half select.
// Latency: 3 cycles with KS_MUL_MIDREG_EN defined, 2 cycles otherwise; throughput 1/cycle.
// Backpressure: per-stage valid/ready; a stage loads when empty or draining; flush kills all in-flight ops.
// Ports: clk, rst_n (async active-low), flush, in_valid/in_ready/in_op/in_a/in_b/in_tag,
//        out_valid/out_ready/out_result/out_tag. Macro KS_MUL_MIDREG_EN adds the register after tree level 1.
module mul_booth_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int EW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH;
  localparam int NPP  = pp_count(WIDTH);
  localparam int NROW = NPP + 1;          // Booth rows plus one row collecting the negation +1 bits
  localparam int NLEV = tree_levels(NROW);
`ifdef KS_MUL_MIDREG_EN
  localparam int NST  = 3;
`else
  localparam int NST  = 2;
`endif

  // ---------------- stage handshake ----------------
  logic [NST-1:0] vld, adv, load;

  always_comb begin
    adv = '0;
    load = '0;
    adv[NST-1]  = vld[NST-1] & out_ready;
    load[NST-1] = ~vld[NST-1] | adv[NST-1];
    for (int k = NST - 2; k >= 0; k--) begin
      adv[k]  = vld[k] & load[k+1];
      load[k] = ~vld[k] | adv[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (load[0]) vld[0] <= in_valid;
      for (int k = 1; k < NST; k++) begin
        if (load[k]) vld[k] <= vld[k-1];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[NST-1];

  // ---------------- operand extension + Booth rows ----------------
  logic            sgn, hi_in;
  logic [EW-1:0]   a_x, b_x;
  logic [EW:0]     b_w;
  logic [NPP-1:0]  neg;
  logic [PW-1:0]   neg_row;
  logic [PW-1:0]   lin  [NLEV][NROW];
  logic [PW-1:0]   lout [NLEV][NROW];

  assign sgn   = (in_op == MUL_OP_MULH);
  assign hi_in = (in_op == MUL_OP_MULH) | (in_op == MUL_OP_MULHU);
  assign a_x   = {{2{sgn & in_a[WIDTH-1]}}, in_a};
  assign b_x   = {{2{sgn & in_b[WIDTH-1]}}, in_b};
  assign b_w   = {b_x, 1'b0};            // implicit b[-1] = 0

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [PW-1:0] row;
    mul_booth_pp #(.WIDTH(WIDTH)) u_pp (
      .a   (a_x),
      .sel (b_w[2*i+2 -: 3]),
      .row (row),
      .neg (neg[i])
    );
    assign lin[0][i] = row << (2 * i);
  end

  always_comb begin
    neg_row = '0;
    for (int i = 0; i < NPP; i++) neg_row[2*i] = neg[i];
  end
  assign lin[0][NPP] = neg_row;

  // ---------------- compressor tree ----------------
  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int NI = rows_at(NROW, l);
    localparam int NQ = NI / 4;
    localparam int NR = NI % 4;
    localparam int NO = rows_at(NROW, l + 1);

    for (genvar g = 0; g < NQ; g++) begin : g_c42
      logic [PW-1:0] s, c;
      logic [PW:0]   k;
      logic          unused_top;
      assign k[0] = 1'b0;
      for (genvar j = 0; j < PW; j++) begin : g_col
        compressor_4to2 u_c42 (
          .x1(lin[l][4*g][j]), .x2(lin[l][4*g+1][j]), .x3(lin[l][4*g+2][j]), .x4(lin[l][4*g+3][j]),
          .cin(k[j]), .sum(s[j]), .carry(c[j]), .cout(k[j+1])
        );
      end
      assign lout[l][2*g]   = s;
      assign lout[l][2*g+1] = {c[PW-2:0], 1'b0};
      // Carries out of the top column fall outside the modulo-2^(2*WIDTH) product.
      assign unused_top     = c[PW-1] ^ k[PW];
    end

    if (NR == 3) begin : g_fa
      logic [PW-1:0] x, y, z, s, c;
      logic          unused_top;
      assign x = lin[l][4*NQ];
      assign y = lin[l][4*NQ+1];
      assign z = lin[l][4*NQ+2];
      assign s = x ^ y ^ z;
      assign c = (x & y) | (x & z) | (y & z);
      assign lout[l][2*NQ]   = s;
      assign lout[l][2*NQ+1] = {c[PW-2:0], 1'b0};
      assign unused_top      = c[PW-1];
    end else begin : g_pass
      for (genvar p = 0; p < NR; p++) begin : g_p
        assign lout[l][2*NQ+p] = lin[l][4*NQ+p];
      end
    end

    for (genvar q = NO; q < NROW; q++) begin : g_zero
      assign lout[l][q] = '0;
    end
  end

  for (genvar r = 0; r < NROW; r++) begin : g_link
    for (genvar l = 2; l < NLEV; l++) begin : g_l
      assign lin[l][r] = lout[l-1][r];
    end
  end

  // ---------------- stage registers ----------------
  logic             mid_vld, mid_hi;
  logic [TAG_W-1:0] mid_tag;

`ifdef KS_MUL_MIDREG_EN
  logic [PW-1:0]    s1_rows [NROW];
  logic             s1_hi;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (load[0] && in_valid) begin
      for (int r = 0; r < NROW; r++) s1_rows[r] <= lout[0][r];
      s1_hi  <= hi_in;
      s1_tag <= in_tag;
    end
  end

  for (genvar r = 0; r < NROW; r++) begin : g_l1
    assign lin[1][r] = s1_rows[r];
  end
  assign mid_vld = vld[0];
  assign mid_hi  = s1_hi;
  assign mid_tag = s1_tag;
`else
  for (genvar r = 0; r < NROW; r++) begin : g_l1
    assign lin[1][r] = lout[0][r];
  end
  assign mid_vld = in_valid;
  assign mid_hi  = hi_in;
  assign mid_tag = in_tag;
`endif

  // Two-row (sum/carry) register feeding the final adder.
  logic [PW-1:0]    r_sum, r_car, prod;
  logic             r_hi;
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk) begin
    if (load[NST-2] && mid_vld) begin
      r_sum <= lout[NLEV-1][0];
      r_car <= lout[NLEV-1][1];
      r_hi  <= mid_hi;
      r_tag <= mid_tag;
    end
  end

  assign prod = r_sum + r_car;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (load[NST-1] && vld[NST-2]) begin
      out_result <= r_hi ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];
      out_tag    <= r_tag;
    end
  end

endmodule
